// File: rtl/dpram_fifo_pkg.sv
// Shared defaults for the DPRAM-backed FIFO and its storage macro.
package dpram_fifo_pkg;

    localparam int unsigned FIFO_A_DEF  = 4;
    localparam int unsigned FIFO_D_DEF  = 32;
    localparam int unsigned DPRAM_LANES = 1;

endpackage

// File: rtl/dpram_fifo_dpram.sv
// Simple dual-port RAM: lane-masked synchronous write, registered synchronous read.
module dpram_fifo_dpram #(
    parameter int unsigned A = 4,
    parameter int unsigned D = 32,
    parameter int unsigned S = 1
) (
    input  logic         clk,
    input  logic         wen,
    input  logic [A-1:0] waddr,
    input  logic [D-1:0] wdata,
    input  logic [S-1:0] wstrb,
    input  logic         ren,
    input  logic [A-1:0] raddr,
    output logic [D-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** A;
    localparam int unsigned LW    = D / S;

    logic [D-1:0] mem [DEPTH];

    // Contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int unsigned l = 0; l < S; l++) begin
                if (wstrb[l]) begin
                    mem[waddr][l*LW +: LW] <= wdata[l*LW +: LW];
                end
            end
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dpram_fifo.sv
// FIFO storing entries in a DPRAM, with a 2-entry registered output buffer
// that hides the one-cycle RAM read latency.
module dpram_fifo
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned A = FIFO_A_DEF,
    parameter int unsigned D = FIFO_D_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [D-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [D-1:0] out_data,
    output logic [A+1:0] cnt
);

    localparam int unsigned DEPTH  = 2 ** A;
    localparam int unsigned RCW    = A + 1;
    localparam int unsigned TCW    = A + 2;
    localparam int unsigned OBUF_N = 2;

    logic [A-1:0]               wptr;
    logic [A-1:0]               rptr;
    logic [RCW-1:0]             ram_cnt;
    logic                       pend;
    logic [1:0]                 obuf_cnt;
    logic [OBUF_N-1:0][D-1:0]   obuf;
    logic [D-1:0]               rdata;

    logic                       push;
    logic                       pop;
    logic                       ren;
    logic [2:0]                 occ_after;
    logic [1:0]                 obuf_cnt_nxt;
    logic [OBUF_N-1:0][D-1:0]   obuf_nxt;

    assign in_rdy   = !rst && (ram_cnt < RCW'(DEPTH));
    assign out_vld  = !rst && (obuf_cnt != 2'd0);
    assign out_data = rst ? '0 : obuf[0];
    assign cnt      = rst ? '0 : TCW'(ram_cnt) + TCW'(pend) + TCW'(obuf_cnt);

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy;

    // Only fetch when the buffer will still have room once the pending word lands.
    assign occ_after = 3'(obuf_cnt) + 3'(pend) - 3'(pop);
    assign ren       = !rst && (ram_cnt != '0) && (occ_after <= 3'd1);

    // Output buffer: shift on pop, then append the RAM word arriving this cycle.
    always_comb begin
        obuf_nxt     = obuf;
        obuf_cnt_nxt = obuf_cnt;
        if (pop) begin
            obuf_nxt[0]  = obuf[1];
            obuf_cnt_nxt = obuf_cnt - 2'd1;
        end
        if (pend) begin
            obuf_nxt[obuf_cnt_nxt[0]] = rdata;
            obuf_cnt_nxt              = obuf_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            pend     <= 1'b0;
            obuf_cnt <= '0;
            obuf     <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + A'(1);
            end
            if (ren) begin
                rptr <= rptr + A'(1);
            end
            if (push && !ren) begin
                ram_cnt <= ram_cnt + RCW'(1);
            end else if (!push && ren) begin
                ram_cnt <= ram_cnt - RCW'(1);
            end
            pend     <= ren;
            obuf_cnt <= obuf_cnt_nxt;
            obuf     <= obuf_nxt;
        end
    end

    dpram_fifo_dpram #(
        .A (A),
        .D (D),
        .S (DPRAM_LANES)
    ) u_ram (
        .clk   (clk),
        .wen   (push),
        .waddr (wptr),
        .wdata (in_data),
        .wstrb ({DPRAM_LANES{1'b1}}),
        .ren   (ren),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dpram_fifo.sv
// Self-checking bench for dpram_fifo (A=2, D=32) against a queue-based model.
module tb_dpram_fifo;

    localparam int unsigned A  = 2;
    localparam int unsigned D  = 32;
    localparam int unsigned CW = A + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic          in_rdy;
    logic [D-1:0]  in_data;
    logic          out_vld;
    logic          out_rdy;
    logic [D-1:0]  out_data;
    logic [CW-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    logic [D-1:0] model_q[$];

    always #5 clk = ~clk;

    dpram_fifo #(.A(A), .D(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .cnt      (cnt)
    );

    // Records the handshakes of the current cycle, then advances to the next negedge.
    task automatic tick(output bit pushed, output bit popped, output logic [D-1:0] pop_data);
        #1;
        pushed   = (in_vld === 1'b1) && (in_rdy === 1'b1);
        popped   = (out_vld === 1'b1) && (out_rdy === 1'b1);
        pop_data = out_data;
        if (pushed) model_q.push_back(in_data);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL rst_in_rdy: got %b expected 0", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL rst_out_vld: got %b expected 0", out_vld); end
        checks++; if (cnt !== CW'(0)) begin failures++; $display("FAIL rst_cnt: got %0d expected 0", cnt); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        rst = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL rst_release_in_rdy: got %b expected 1", in_rdy); end
        model_q.delete();
        @(negedge clk);
    endtask

    task automatic test_latency();
        bit p, q;
        logic [D-1:0] d, exp;
        in_vld = 1'b1; in_data = 32'h11; out_rdy = 1'b0;
        tick(p, q, d);
        checks++; if (p !== 1'b1) begin failures++; $display("FAIL lat_push: got %b expected 1", p); end
        in_vld = 1'b0; in_data = $urandom;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (cnt !== CW'(1)) begin failures++; $display("FAIL lat_cnt c%0d: got %0d expected 1", c, cnt); end
            checks++;
            if (out_vld !== (c == 3)) begin failures++; $display("FAIL lat_out_vld c%0d: got %b expected %b", c, out_vld, (c == 3)); end
            if (c == 3) begin
                checks++; if (out_data !== 32'h11) begin failures++; $display("FAIL lat_out_data: got %0h expected 11", out_data); end
                out_rdy = 1'b1;
            end
            tick(p, q, d);
        end
        checks++;
        if (!q || model_q.size() == 0) begin
            failures++; $display("FAIL lat_pop: got popped=%b expected 1", q);
        end else begin
            exp = model_q.pop_front();
            if (d !== exp) begin failures++; $display("FAIL lat_pop_data: got %0h expected %0h", d, exp); end
        end
        out_rdy = 1'b0;
        checks++; if (cnt !== CW'(0)) begin failures++; $display("FAIL lat_empty_cnt: got %0d expected 0", cnt); end
    endtask

    task automatic test_fill();
        bit p, q;
        logic [D-1:0] d, exp;
        int acc = 0;
        int idx = 1;
        bit got7 = 1'b0;
        out_rdy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_vld = 1'b1; in_data = D'(idx);
            tick(p, q, d);
            if (p) begin acc++; idx++; end
        end
        checks++; if (acc != 6) begin failures++; $display("FAIL fill_accepted: got %0d expected 6", acc); end
        checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL fill_in_rdy: got %b expected 0", in_rdy); end
        checks++; if (cnt !== CW'(6)) begin failures++; $display("FAIL fill_cnt: got %0d expected 6", cnt); end
        checks++; if (out_vld !== 1'b1 || out_data !== 32'h1) begin failures++; $display("FAIL fill_head: got vld=%b data=%0h expected vld=1 data=1", out_vld, out_data); end
        out_rdy = 1'b1;
        tick(p, q, d);
        checks++; if (p) begin failures++; $display("FAIL fill_7th_early: got pushed=1 expected 0"); end
        checks++;
        if (!q) begin failures++; $display("FAIL fill_pop: got popped=0 expected 1"); end
        else begin
            exp = model_q.pop_front();
            if (d !== exp) begin failures++; $display("FAIL fill_pop_data: got %0h expected %0h", d, exp); end
        end
        out_rdy = 1'b0;
        for (int c = 0; c < 10 && !got7; c++) begin
            tick(p, q, d);
            if (p) got7 = 1'b1;
        end
        checks++; if (!got7) begin failures++; $display("FAIL fill_7th_accept: got 0 expected 1"); end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 40 && model_q.size() > 0; c++) begin
            tick(p, q, d);
            if (q) begin
                exp = model_q.pop_front();
                checks++; if (d !== exp) begin failures++; $display("FAIL fill_drain_data: got %0h expected %0h", d, exp); end
            end
        end
        out_rdy = 1'b0;
        checks++; if (model_q.size() != 0 || cnt !== CW'(0)) begin failures++; $display("FAIL fill_drained: got left=%0d cnt=%0d expected 0", model_q.size(), cnt); end
    endtask

    task automatic test_back_to_back();
        bit p, q;
        logic [D-1:0] d, exp;
        int npop = 0;
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            in_vld = (cyc < 100); in_data = D'(cyc);
            if (cyc >= 3 && cyc <= 99) begin
                checks++; if (cnt !== CW'(3)) begin failures++; $display("FAIL b2b_cnt c%0d: got %0d expected 3", cyc, cnt); end
                checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL b2b_in_rdy c%0d: got %b expected 1", cyc, in_rdy); end
            end
            tick(p, q, d);
            if (q) begin
                exp = model_q.pop_front();
                checks++; if (d !== exp) begin failures++; $display("FAIL b2b_data: got %0h expected %0h", d, exp); end
                checks++; if (cyc != 3 + npop) begin failures++; $display("FAIL b2b_timing: got cycle %0d expected %0d", cyc, 3 + npop); end
                npop++;
            end
        end
        in_vld = 1'b0; out_rdy = 1'b0;
        checks++; if (npop != 100) begin failures++; $display("FAIL b2b_count: got %0d expected 100", npop); end
    endtask

    task automatic test_random();
        bit p, q;
        logic [D-1:0] d, exp;
        logic [D-1:0] data_prev = '0;
        bit stall_prev = 1'b0;
        bit stall_now;
        int pushes = 0;
        for (int cyc = 0; cyc < 20000 && pushes < 1000; cyc++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            out_rdy = ($urandom_range(0, 1) != 0);
            checks++; if (cnt !== CW'(model_q.size())) begin failures++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", cyc, cnt, model_q.size()); end
            if (stall_prev) begin
                checks++;
                if (out_vld !== 1'b1 || out_data !== data_prev) begin
                    failures++; $display("FAIL rnd_stall c%0d: got vld=%b data=%0h expected vld=1 data=%0h", cyc, out_vld, out_data, data_prev);
                end
            end
            stall_now = (out_vld === 1'b1) && !out_rdy;
            data_prev = out_data;
            tick(p, q, d);
            stall_prev = stall_now;
            if (p) pushes++;
            if (q) begin
                checks++;
                if (model_q.size() == 0) begin failures++; $display("FAIL rnd_underflow: got pop expected none"); end
                else begin
                    exp = model_q.pop_front();
                    if (d !== exp) begin failures++; $display("FAIL rnd_data: got %0h expected %0h", d, exp); end
                end
            end
        end
        checks++; if (pushes != 1000) begin failures++; $display("FAIL rnd_pushes: got %0d expected 1000", pushes); end
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 50 && model_q.size() > 0; c++) begin
            tick(p, q, d);
            if (q) begin
                exp = model_q.pop_front();
                checks++; if (d !== exp) begin failures++; $display("FAIL rnd_drain_data: got %0h expected %0h", d, exp); end
            end
        end
        out_rdy = 1'b0;
        checks++; if (model_q.size() != 0 || cnt !== CW'(0)) begin failures++; $display("FAIL rnd_drained: got left=%0d cnt=%0d expected 0", model_q.size(), cnt); end
    endtask

    task automatic test_reset_mid();
        bit p, q;
        logic [D-1:0] d, exp;
        out_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_vld = 1'b1; in_data = D'(32'h100 + c);
            out_rdy = (c != 6);
            tick(p, q, d);
            if (q) begin
                exp = model_q.pop_front();
                checks++; if (d !== exp) begin failures++; $display("FAIL rmid_pre_data: got %0h expected %0h", d, exp); end
            end
        end
        checks++; if (cnt !== CW'(4)) begin failures++; $display("FAIL rmid_pre_cnt: got %0d expected 4", cnt); end
        rst = 1'b1; in_vld = 1'b1; in_data = 32'hDEAD; out_rdy = 1'b1;
        tick(p, q, d);
        checks++; if (p || q) begin failures++; $display("FAIL rmid_hs_in_rst: got push=%b pop=%b expected 0 0", p, q); end
        model_q.delete();
        rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0 || cnt !== CW'(0)) begin failures++; $display("FAIL rmid_cleared: got vld=%b cnt=%0d expected 0 0", out_vld, cnt); end
        checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL rmid_in_rdy: got %b expected 1", in_rdy); end
        in_vld = 1'b1; in_data = 32'hAA;
        tick(p, q, d);
        in_vld = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (out_vld !== (c == 3)) begin failures++; $display("FAIL rmid_vld c%0d: got %b expected %b", c, out_vld, (c == 3)); end
            checks++; if (cnt !== CW'(1)) begin failures++; $display("FAIL rmid_cnt c%0d: got %0d expected 1", c, cnt); end
            if (c == 3) out_rdy = 1'b1;
            tick(p, q, d);
        end
        checks++;
        if (!q || model_q.size() == 0) begin failures++; $display("FAIL rmid_pop: got popped=%b expected 1", q); end
        else begin
            exp = model_q.pop_front();
            if (d !== exp) begin failures++; $display("FAIL rmid_data: got %0h expected %0h", d, exp); end
        end
        out_rdy = 1'b0;
        tick(p, q, d);
        checks++; if (out_vld !== 1'b0 || cnt !== CW'(0)) begin failures++; $display("FAIL rmid_stale: got vld=%b cnt=%0d expected 0 0", out_vld, cnt); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
